priority_decoder3to8_seq: RTL
=============================

# priority_decoder3to8_seq

Registered 3-to-8 decoder for the code stream produced by the 8-to-3 priority encoder, which outputs a 3-bit code `y` and an `idle` flag. The block accepts one code per valid/ready handshake and drives the matching one-hot line for a fixed number of cycles. It then inserts a one-cycle all-zero gap before accepting the next code. It also keeps a sticky 8-bit history of decoded lines, which software or a monitor clears explicitly.

## Interface
Parameters:
- `HOLD`, default 4: cycles each decoded line stays asserted. Legal range 1..255.

Ports:
- `clk`, input, 1 bit: clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit: synchronous reset, active-low. Sampled on the rising edge of `clk`.
- `y`, input, 3 bits: encoded line index from the encoder.
- `idle`, input, 1 bit: 1 means the encoder saw no active input, so `y` is don't-care.
- `in_valid`, input, 1 bit: `y` and `idle` are valid this cycle.
- `in_ready`, output, 1 bit: block can accept a code this cycle.
- `data_out`, output, 8 bits: one-hot decoded line, or all zeros.
- `out_valid`, output, 1 bit: `data_out` currently carries a decoded line.
- `idle_seen`, output, 1 bit: one-cycle pulse when an `idle=1` code is accepted.
- `last_code`, output, 3 bits: `y` of the most recent accepted non-idle code.
- `history`, output, 8 bits: sticky OR of every line decoded since reset or the last clear.
- `hist_clr`, input, 1 bit: synchronous clear of `history`.

## Operation
- Accept event: `in_valid && in_ready` at a rising edge.
- The FSM has three states:
  - S_IDLE: `in_ready`=1, `data_out`=0, `out_valid`=0.
    - Accept with `idle=0`: go to S_DRIVE, load the hold counter with `HOLD`, register `data_out = 1 << y`, set `last_code = y`, and set `history[y]`.
    - Accept with `idle=1`: stay in S_IDLE and pulse `idle_seen` for one cycle. `data_out`, `last_code` and `history` are unchanged.
  - S_DRIVE: `in_ready`=0, `out_valid`=1, `data_out` holds its one-hot value. The counter decrements every cycle. When the counter reaches 1, go to S_GAP.
  - S_GAP: `in_ready`=0, `data_out`=0, `out_valid`=0. Always returns to S_IDLE on the next edge.
- `data_out` is always either all zeros or exactly one hot. It is never X or Z, including for an `idle=1` code.
- `history` update rule:
  - `hist_clr` with no accept: `history` becomes 0.
  - `hist_clr` together with a non-idle accept: `history` becomes exactly `1 << y` (the clear applies first, then the new bit is set).
- Counter width is ceil(log2(HOLD+1)) bits. It never wraps.
- `in_valid` is ignored while `in_ready`=0. The producer must hold its data until accepted; no input is buffered.
- Reset values (`rst_n`=0 at an edge), taking priority over all other activity including mid-drive:
  - state = S_IDLE, `in_ready`=1
  - `data_out`=0, `out_valid`=0, `idle_seen`=0
  - `last_code`=0, `history`=0, counter=0

## Timing
- Non-idle accept at edge k:
  - `data_out` is one-hot during cycles k+1 through k+HOLD.
  - Cycle k+HOLD+1 is the gap cycle.
  - `in_ready`=1 again from cycle k+HOLD+2.
  - Non-idle throughput is therefore one code per HOLD+2 cycles.
- Idle accept at edge k: `idle_seen`=1 during cycle k+1 only, and `in_ready` stays 1. Back-to-back idle codes are accepted every cycle.
- `history` and `last_code` update at the accept edge, so the new values are visible in cycle k+1.
- With `HOLD`=1, S_DRIVE lasts exactly one cycle.
- `in_ready` is a function of state only. It has no combinational path from `in_valid`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, then release. Required: `data_out`=0x00, `history`=0x00, `in_ready`=1, `out_valid`=0.
- Single decode: with `HOLD`=4, send `y`=5, `idle`=0 at edge k. Required:
  - `data_out`=0x20 and `out_valid`=1 during cycles k+1 to k+4.
  - `data_out`=0x00 in cycle k+5.
  - `in_ready`=1 in cycle k+6.
  - `last_code`=5, `history`=0x20.
- Backpressure: hold `in_valid`=1 with `y`=2 during S_DRIVE of a `y`=7 code. Required: the second code is accepted only at the first S_IDLE cycle, `history`=0x84, and at most one `data_out` bit is ever set.
- Idle stream: apply `idle`=1 with `in_valid`=1 for 3 consecutive cycles. Required: `idle_seen` high for 3 cycles, `data_out` stays 0x00, `in_ready` stays 1, `history` unchanged.
- Clear collision: with `history`=0x0F, assert `hist_clr` on the same edge as accepting `y`=6. Required: `history`=0x40.
- Reset mid-operation: assert `rst_n`=0 during the second S_DRIVE cycle. Required at the next edge: `data_out`=0x00, `out_valid`=0, `history`=0x00, `in_ready`=1.

Source files
------------

// File: rtl/priority_decoder3to8_seq.sv
// Registered 3-to-8 decoder for a priority-encoder code stream: one code per handshake,
// each decoded line held for HOLD cycles, then a one-cycle all-zero gap, plus a sticky history.
module priority_decoder3to8_seq #(
    parameter int unsigned HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] y,
    input  logic       idle,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       idle_seen,
    output logic [2:0] last_code,
    output logic [7:0] history,
    input  logic       hist_clr
);

    localparam int unsigned CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    data_out_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic          idle_seen_q;
    logic [2:0]    last_code_q;
    logic [7:0]    history_q;
    logic [7:0]    history_d;
    logic          accept;
    logic [7:0]    line;

    always_comb begin
        accept = in_valid && in_ready_q;
        line   = 8'(1) << y;
    end

    // Clear takes effect first so a colliding non-idle accept leaves only its own bit.
    always_comb begin
        history_d = hist_clr ? '0 : history_q;
        if (accept && !idle) begin
            history_d = history_d | line;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            idle_seen_q <= 1'b0;
            last_code_q <= '0;
            history_q   <= '0;
        end else begin
            idle_seen_q <= 1'b0;
            history_q   <= history_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (idle) begin
                            idle_seen_q <= 1'b1;
                        end else begin
                            state_q     <= S_DRIVE;
                            cnt_q       <= CW'(HOLD);
                            data_out_q  <= line;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            last_code_q <= y;
                        end
                    end
                end
                S_DRIVE: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_GAP;
                        data_out_q  <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    data_out_q  <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign idle_seen = idle_seen_q;
    assign last_code = last_code_q;
    assign history   = history_q;

endmodule
